// File: rtl/seq_detect_param_if.sv
// Serial-bit stream in, match flag/prefix state/match count out.
// No registers inside; it only groups the signals.
// No back-pressure: every bit with valid=1 is consumed on that edge.
interface seq_detect_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int SW = $clog2(N);

  logic             x;
  logic             valid;
  logic             clr_cnt;
  logic             z;
  logic [SW-1:0]    state;
  logic [CNT_W-1:0] match_cnt;

  // Stream source / consumer side
  modport master (
    output x, valid, clr_cnt,
    input  z, state, match_cnt
  );

  // Detector side
  modport slave (
    input  x, valid, clr_cnt,
    output z, state, match_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// Mealy detector for a programmable N-bit serial pattern with a saturating match counter.
// z is combinational in the cycle the last bit arrives; state/match_cnt update one edge later.
// No back-pressure: a bit is consumed on every edge with valid=1; valid=0 holds state.
module seq_detect_param #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1001,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_detect_param_if.slave   bus
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0]    LAST    = SW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Builds the full transition table: entry (k, b) holds the next matched-prefix
  // length after bit b arrives in state k. It is the longest prefix of PATTERN,
  // shorter than N, that is a suffix of prefix_k followed by b. A full match
  // therefore lands on the longest proper border, unless overlap is disabled.
  function automatic logic [2*N*SW-1:0] build_tbl();
    logic [2*N*SW-1:0] t;
    int                best;
    int                j;
    logic              ok;
    logic              sb;
    t = '0;
    for (int k = 0; k < N; k++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        for (int len = 1; (len <= k + 1) && (len < N); len++) begin
          ok = 1'b1;
          for (int i = 0; i < len; i++) begin
            j  = k + 1 - len + i;
            sb = (j == k) ? b[0] : PATTERN[N-1-j];
            if (sb != PATTERN[N-1-i]) ok = 1'b0;
          end
          if (ok) best = len;
        end
        if (!OVERLAP && (k == N - 1) && (b[0] == PATTERN[0])) best = 0;
        t[(k*2+b)*SW +: SW] = best[SW-1:0];
      end
    end
    return t;
  endfunction

  localparam logic [2*N*SW-1:0] NXT_TBL = build_tbl();

  logic [SW-1:0]    r_state;
  logic [SW-1:0]    w_state_nxt;
  logic [SW:0]      w_idx;
  logic             w_z;
  logic [CNT_W-1:0] r_cnt;

  // Next-state lookup and the Mealy match flag
  always_comb begin
    w_idx       = {r_state, bus.x};
    w_state_nxt = r_state;
    w_z         = 1'b0;
    if (bus.valid) begin
      w_state_nxt = NXT_TBL[w_idx*SW +: SW];
      w_z         = ~reset & (r_state == LAST) & (bus.x == PATTERN[0]);
    end
  end

  // Matched-prefix state register; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) r_state <= '0;
    else       r_state <= w_state_nxt;
  end

  // Saturating match counter: reset > clr_cnt > increment
  always_ff @(posedge clk) begin
    if (reset)                       r_cnt <= '0;
    else if (bus.clr_cnt)            r_cnt <= '0;
    else if (w_z && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.z         = w_z;
  assign bus.state     = r_state;
  assign bus.match_cnt = r_cnt;

endmodule
